count_code_led_receiver: RTL and testbench

- Receiving end of the 4-bit count-code link: consumes the slow count clock and 4-bit count value produced by the up/down counter block.
- Safely brings both signals into the clk100MHz domain.
- Classifies each new code as step-up, step-down, repeat or jump.
- Drives a 16-LED waterfall: one-hot head with an optional trailing tail, plus direction, wrap and error status for the board display.

---
 rtl/count_code_led_receiver.sv | 189 ++++++++++++++++++
 tb/tb_count_code_led_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/count_code_led_receiver.sv
// count_code_led_receiver
// Receiving end of the 4-bit count-code link. It synchronizes the slow count
// clock and the count value into clk100MHz, then waits a settle window after
// each count-clock rise before capturing the code. Each capture is classified
// as step-up, step-down, repeat or jump, and the result drives a 16-LED
// waterfall plus direction, wrap and error status.
module count_code_led_receiver #(
    parameter int SETTLE    = 4,
    parameter int TRAIL_LEN = 3
) (
    input  logic        clk100MHz,
    input  logic        reset,
    input  logic        code_clk,
    input  logic [3:0]  code,
    input  logic        trail_en,
    output logic [15:0] led,
    output logic        dir,
    output logic        update,
    output logic        wrap,
    output logic        jump_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Waterfall pattern: head bit plus an optional tail trailing opposite to dir.
    function automatic logic [15:0] led_map(
        input logic [3:0] head,
        input logic       head_dir,
        input logic       trail,
        input logic       head_valid
    );
        logic [15:0] m;
        logic [3:0]  k4;
        logic [3:0]  idx;
        m = 16'h0000;
        if (head_valid) begin
            m[head] = 1'b1;
            if (trail) begin
                for (int k = 1; k <= 15; k++) begin
                    k4  = k[3:0];
                    idx = head_dir ? (head - k4) : (head + k4);
                    if (k <= TRAIL_LEN) begin
                        m[idx] = 1'b1;
                    end else begin
                        m[idx] = m[idx];
                    end
                end
            end else begin
                m = m;
            end
        end else begin
            m = 16'h0000;
        end
        return m;
    endfunction

    logic        clk_s1_r, clk_s2_r, clk_s3_r;
    logic [3:0]  code_s1_r, code_s2_r;
    logic        edge_s;

    state_t      state_r;
    logic [3:0]  settle_cnt_r;
    logic [3:0]  head_r;
    logic        valid_r;
    logic        dir_r;
    logic        update_r, wrap_r, jump_err_r;
    logic [7:0]  err_cnt_r;
    logic [15:0] led_r;

    logic [3:0]  delta_s;
    logic [3:0]  head_nxt_s;
    logic        dir_nxt_s, valid_nxt_s;
    logic        upd_s, wrap_s, jump_s;

    // Two-flop synchronizers for count clock and code, plus edge history flop.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            clk_s1_r  <= 1'b0;
            clk_s2_r  <= 1'b0;
            clk_s3_r  <= 1'b0;
            code_s1_r <= 4'd0;
            code_s2_r <= 4'd0;
        end else begin
            clk_s1_r  <= code_clk;
            clk_s2_r  <= clk_s1_r;
            clk_s3_r  <= clk_s2_r;
            code_s1_r <= code;
            code_s2_r <= code_s1_r;
        end
    end

    assign edge_s = clk_s2_r & ~clk_s3_r;

    // Classification of the captured code against the current head.
    always_comb begin
        delta_s     = code_s2_r - head_r;
        head_nxt_s  = head_r;
        dir_nxt_s   = dir_r;
        valid_nxt_s = valid_r;
        upd_s       = 1'b0;
        wrap_s      = 1'b0;
        jump_s      = 1'b0;
        if (state_r == ST_CAPTURE) begin
            head_nxt_s  = code_s2_r;
            valid_nxt_s = 1'b1;
            upd_s       = 1'b1;
            if (!valid_r) begin
                dir_nxt_s = dir_r;
            end else if (delta_s == 4'd1) begin
                dir_nxt_s = 1'b1;
                wrap_s    = (head_r == 4'd15);
            end else if (delta_s == 4'd15) begin
                dir_nxt_s = 1'b0;
                wrap_s    = (head_r == 4'd0);
            end else if (delta_s == 4'd0) begin
                dir_nxt_s = dir_r;
            end else begin
                jump_s = 1'b1;
            end
        end else begin
            upd_s = 1'b0;
        end
    end

    // Capture FSM with registered status, counters and LED map.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            head_r       <= 4'd0;
            valid_r      <= 1'b0;
            dir_r        <= 1'b1;
            update_r     <= 1'b0;
            wrap_r       <= 1'b0;
            jump_err_r   <= 1'b0;
            err_cnt_r    <= 8'd0;
            led_r        <= 16'h0000;
        end else begin
            head_r     <= head_nxt_s;
            valid_r    <= valid_nxt_s;
            dir_r      <= dir_nxt_s;
            update_r   <= upd_s;
            wrap_r     <= wrap_s;
            jump_err_r <= jump_s;
            led_r      <= led_map(head_nxt_s, dir_nxt_s, trail_en, valid_nxt_s);
            if (jump_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= 4'(SETTLE - 1);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == 4'd0) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign led      = led_r;
    assign dir      = dir_r;
    assign update   = update_r;
    assign wrap     = wrap_r;
    assign jump_err = jump_err_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_count_code_led_receiver.sv
// Directed self-checking bench for count_code_led_receiver (SETTLE=4, TRAIL_LEN=3).
module tb_count_code_led_receiver;

    logic        clk100MHz = 1'b0;
    logic        reset     = 1'b0;
    logic        code_clk  = 1'b0;
    logic [3:0]  code      = 4'd0;
    logic        trail_en  = 1'b0;
    logic [15:0] led;
    logic        dir, update, wrap, jump_err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    // Values captured at the update pulse of the last transaction.
    int          lat;
    logic        c_wrap, c_jump, c_dir, c_upd_after, c_wrap_after;
    logic [15:0] c_led;
    logic [7:0]  c_err;

    count_code_led_receiver #(.SETTLE(4), .TRAIL_LEN(3)) dut (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .code_clk  (code_clk),
        .code      (code),
        .trail_en  (trail_en),
        .led       (led),
        .dir       (dir),
        .update    (update),
        .wrap      (wrap),
        .jump_err  (jump_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One code_clk rise carrying value v; records state at the update pulse.
    task automatic cap(input logic [3:0] v);
        bit found;
        found = 1'b0;
        lat   = 0;
        @(negedge clk100MHz);
        code     = v;
        code_clk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk100MHz);
            if (!found && update) begin
                found  = 1'b1;
                lat    = i;
                c_wrap = wrap;
                c_jump = jump_err;
                c_dir  = dir;
                c_led  = led;
                c_err  = err_cnt;
                @(negedge clk100MHz);
                c_upd_after  = update;
                c_wrap_after = wrap;
                break;
            end
        end
        code_clk = 1'b0;
        repeat (4) @(negedge clk100MHz);
    endtask

    initial begin
        int jumps;
        int upd_count;
        logic [15:0] led_before;

        // Reset state
        #12;
        chk("rst_led", led, 16'h0000);
        chk("rst_dir", dir, 1'b1);
        chk("rst_update", update, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_jump", jump_err, 1'b0);
        chk("rst_errcnt", err_cnt, 8'd0);
        @(negedge clk100MHz);
        reset = 1'b1;
        repeat (3) @(negedge clk100MHz);

        // First capture: code 5
        cap(4'd5);
        chk("first_latency", lat, 8);
        chk("first_led", c_led, 16'h0020);
        chk("first_dir", c_dir, 1'b1);
        chk("first_wrap", c_wrap, 1'b0);
        chk("first_jump", c_jump, 1'b0);
        chk("first_upd_1cyc", c_upd_after, 1'b0);

        // Up sequence 14,15,0 with trail
        trail_en = 1'b1;
        cap(4'd14);
        chk("up14_jump", c_jump, 1'b1);
        chk("up14_err", c_err, 8'd1);
        cap(4'd15);
        chk("up15_wrap", c_wrap, 1'b0);
        chk("up15_led", c_led, 16'hF000);
        chk("up15_dir", c_dir, 1'b1);
        cap(4'd0);
        chk("up0_wrap", c_wrap, 1'b1);
        chk("up0_wrap_1cyc", c_wrap_after, 1'b0);
        chk("up0_led", c_led, 16'hE001);
        chk("up0_dir", c_dir, 1'b1);
        chk("up0_jump", c_jump, 1'b0);

        // trail_en change takes effect on the next cycle
        @(negedge clk100MHz);
        trail_en = 1'b0;
        @(negedge clk100MHz);
        chk("trail_off_led", led, 16'h0001);

        // Down sequence 1,0,15 without trail
        cap(4'd1);
        chk("dn1_dir", c_dir, 1'b1);
        chk("dn1_wrap", c_wrap, 1'b0);
        cap(4'd0);
        chk("dn0_dir", c_dir, 1'b0);
        chk("dn0_wrap", c_wrap, 1'b0);
        chk("dn0_led", c_led, 16'h0001);
        cap(4'd15);
        chk("dn15_wrap", c_wrap, 1'b1);
        chk("dn15_dir", c_dir, 1'b0);
        chk("dn15_led", c_led, 16'h8000);

        // Jumps 15->3->9, then 260 more jumps
        cap(4'd3);
        chk("j3_jump", c_jump, 1'b1);
        cap(4'd9);
        chk("j9_jump", c_jump, 1'b1);
        chk("j9_led", c_led, 16'h0200);
        chk("j9_dir", c_dir, 1'b0);
        chk("j9_err", c_err, 8'd3);
        jumps = 0;
        for (int i = 0; i < 260; i++) begin
            cap((i % 2 == 0) ? 4'd3 : 4'd9);
            if (c_jump === 1'b1 && lat == 8) jumps++;
        end
        chk("jump_pulses", jumps, 260);
        chk("err_saturated", err_cnt, 8'd255);
        chk("jump_dir_kept", dir, 1'b0);

        // Repeat 7->7 with a second edge inside the settle window
        cap(4'd7);
        chk("rep_pre_err_sat", c_err, 8'd255);
        led_before = led;
        chk("rep_pre_led", led_before, 16'h0080);
        upd_count = 0;
        @(negedge clk100MHz);
        code     = 4'd7;
        code_clk = 1'b1;
        @(negedge clk100MHz);
        code_clk = 1'b0;
        if (update) upd_count++;
        @(negedge clk100MHz);
        code_clk = 1'b1;
        if (update) upd_count++;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk100MHz);
            if (update) begin
                upd_count++;
                c_wrap = wrap;
                c_jump = jump_err;
                c_led  = led;
            end
        end
        chk("rep_single_update", upd_count, 1);
        chk("rep_wrap", c_wrap, 1'b0);
        chk("rep_jump", c_jump, 1'b0);
        chk("rep_led", c_led, 16'h0080);
        chk("rep_dir", dir, 1'b0);
        code_clk = 1'b0;
        repeat (4) @(negedge clk100MHz);

        // Reset during SETTLE
        @(negedge clk100MHz);
        code     = 4'd2;
        code_clk = 1'b1;
        repeat (4) @(negedge clk100MHz);
        reset = 1'b0;
        #1;
        chk("mid_rst_led", led, 16'h0000);
        chk("mid_rst_dir", dir, 1'b1);
        chk("mid_rst_err", err_cnt, 8'd0);
        chk("mid_rst_update", update, 1'b0);
        code_clk = 1'b0;
        repeat (2) @(negedge clk100MHz);
        reset = 1'b1;
        upd_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk100MHz);
            if (update) upd_count++;
        end
        chk("post_rst_no_update", upd_count, 0);
        cap(4'd4);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_jump", c_jump, 1'b0);
        chk("post_rst_led", c_led, 16'h0010);
        chk("post_rst_dir", c_dir, 1'b1);
        chk("post_rst_err", c_err, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
